// File: rtl/ivd_pkg.sv
// Shared types and helpers for the IVD assay sequencer.
//   state_e    : sequencer FSM states
//   MIN_PHASE  : shortest phase length in cycles (a programmed 0 becomes this)
//   lowest_set : lowest set bit of a mask at or above a start index
package ivd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FILL,
    ST_MIX,
    ST_DETECT,
    ST_RESULT,
    ST_FLUSH,
    ST_FINISH
  } state_e;

  localparam int unsigned MIN_PHASE = 1;

  // Returns {found, index}. The mask is zero-extended to 32 bits by the caller.
  function automatic logic [5:0] lowest_set(input logic [31:0] mask, input logic [4:0] from);
    logic [5:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/ivd_phase_timer.sv
// Phase-duration down-counter shared by the fill, mix, detect and flush phases.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (0 is clamped to MIN_PHASE)
//   load_val   : phase length in cycles
//   expire     : counter reads MIN_PHASE, i.e. last cycle of the phase
module ivd_phase_timer
  import ivd_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (load_val == '0) ? TIMER_W'(MIN_PHASE) : load_val;
    end else if (cnt_q > TIMER_W'(MIN_PHASE)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == TIMER_W'(MIN_PHASE));

endmodule

// File: rtl/ivd_assay_sequencer.sv
// Runs each enabled channel in ascending order through fill, mix, detect and
// flush, capturing one detector reading per channel onto a valid/ready port.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, ch_mask, *_cycles, det_timeout : run request and configuration
//   valve_*, mix_en, det_en, flush_en     : registered one-hot channel drives
//   det_valid, det_data   : detector reading for the active channel
//   res_*                 : result handshake (channel, reading, timeout flag)
//   busy, done            : run in progress, end-of-run pulse
//
// state     | meaning
// IDLE      | waiting for start
// SELECT    | pick next enabled channel or finish
// FILL      | sample and reagent inlets open
// MIX       | mixer pump on
// DETECT    | detector on, waiting for reading or timeout
// RESULT    | result offered, all valves closed
// FLUSH     | flush valve open, channel retired at end
// FINISH    | done pulse
module ivd_assay_sequencer
  import ivd_pkg::*;
#(
  parameter int N_CH    = 6,
  parameter int TIMER_W = 16,
  parameter int DATA_W  = 12,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [TIMER_W-1:0] fill_cycles,
  input  logic [TIMER_W-1:0] mix_cycles,
  input  logic [TIMER_W-1:0] det_timeout,
  input  logic [TIMER_W-1:0] flush_cycles,
  output logic [N_CH-1:0]    valve_sample,
  output logic [N_CH-1:0]    valve_reagent,
  output logic [N_CH-1:0]    mix_en,
  output logic [N_CH-1:0]    det_en,
  output logic [N_CH-1:0]    flush_en,
  input  logic               det_valid,
  input  logic [DATA_W-1:0]  det_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CH_W-1:0]    res_ch,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [TIMER_W-1:0] fill_q, mix_q, det_to_q, flush_q;
  logic               tmr_load, tmr_expire;
  logic [TIMER_W-1:0] tmr_val;
  logic               cap;
  logic [DATA_W-1:0]  cap_data;
  logic               cap_to;
  logic [5:0]         sel;
  logic [N_CH-1:0]    oh_d;

  ivd_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mask_d   = mask_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    cap      = 1'b0;
    cap_data = '0;
    cap_to   = 1'b0;
    sel      = lowest_set(32'(mask_q), 5'(ch_q));
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SELECT;
      ST_SELECT: begin
        if (sel[5]) begin
          ch_d     = CH_W'(sel[4:0]);
          state_d  = ST_FILL;
          tmr_load = 1'b1;
          tmr_val  = fill_q;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FILL: if (tmr_expire) begin
        state_d  = ST_MIX;
        tmr_load = 1'b1;
        tmr_val  = mix_q;
      end
      ST_MIX: if (tmr_expire) begin
        state_d  = ST_DETECT;
        tmr_load = 1'b1;
        tmr_val  = det_to_q;
      end
      ST_DETECT: begin
        // A reading on the expiry cycle still counts as data.
        if (det_valid) begin
          cap      = 1'b1;
          cap_data = det_data;
          state_d  = ST_RESULT;
        end else if (tmr_expire) begin
          cap     = 1'b1;
          cap_to  = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: if (res_ready) begin
        state_d  = ST_FLUSH;
        tmr_load = 1'b1;
        tmr_val  = flush_q;
      end
      ST_FLUSH: if (tmr_expire) begin
        mask_d[ch_q] = 1'b0;
        state_d      = ST_SELECT;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign oh_d = N_CH'(1) << ch_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ch_q          <= '0;
      mask_q        <= '0;
      fill_q        <= '0;
      mix_q         <= '0;
      det_to_q      <= '0;
      flush_q       <= '0;
      valve_sample  <= '0;
      valve_reagent <= '0;
      mix_en        <= '0;
      det_en        <= '0;
      flush_en      <= '0;
      res_valid     <= 1'b0;
      res_ch        <= '0;
      res_data      <= '0;
      res_timeout   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        ch_q     <= '0;
        mask_q   <= ch_mask;
        fill_q   <= fill_cycles;
        mix_q    <= mix_cycles;
        det_to_q <= det_timeout;
        flush_q  <= flush_cycles;
      end else begin
        ch_q   <= ch_d;
        mask_q <= mask_d;
      end
      if (cap) begin
        res_ch      <= ch_q;
        res_data    <= cap_data;
        res_timeout <= cap_to;
      end
      valve_sample  <= (state_d == ST_FILL)   ? oh_d : '0;
      valve_reagent <= (state_d == ST_FILL)   ? oh_d : '0;
      mix_en        <= (state_d == ST_MIX)    ? oh_d : '0;
      det_en        <= (state_d == ST_DETECT) ? oh_d : '0;
      flush_en      <= (state_d == ST_FLUSH)  ? oh_d : '0;
      res_valid     <= (state_d == ST_RESULT);
      busy          <= (state_d != ST_IDLE);
      done          <= (state_d == ST_FINISH);
    end
  end

endmodule

// File: tb/tb_ivd_assay_sequencer.sv
// Directed bench for ivd_assay_sequencer with N_CH=6, TIMER_W=16, DATA_W=12.
module tb_ivd_assay_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  ch_mask;
  logic [15:0] fill_cycles, mix_cycles, det_timeout, flush_cycles;
  logic [5:0]  valve_sample, valve_reagent, mix_en, det_en, flush_en;
  logic        det_valid;
  logic [11:0] det_data;
  logic        res_valid, res_ready;
  logic [2:0]  res_ch;
  logic [11:0] res_data;
  logic        res_timeout, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  ivd_assay_sequencer #(.N_CH(6), .TIMER_W(16), .DATA_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
    .fill_cycles(fill_cycles), .mix_cycles(mix_cycles),
    .det_timeout(det_timeout), .flush_cycles(flush_cycles),
    .valve_sample(valve_sample), .valve_reagent(valve_reagent),
    .mix_en(mix_en), .det_en(det_en), .flush_en(flush_en),
    .det_valid(det_valid), .det_data(det_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_data(res_data), .res_timeout(res_timeout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] drives();
    return {valve_sample, valve_reagent, mix_en, det_en, flush_en};
  endfunction

  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic start_run(input logic [5:0] m, input int f, input int mx, input int dt, input int fl);
    ch_mask      = m;
    fill_cycles  = 16'(f);
    mix_cycles   = 16'(mx);
    det_timeout  = 16'(dt);
    flush_cycles = 16'(fl);
    start        = 1'b1;
    tick();
    start   = 1'b0;
    ch_mask = ~m;                 // must have been latched already
    chk("select_busy", {31'd0, busy}, 32'd1);
    chk("select_drives", {2'b0, drives()}, 32'd0);
    chk("select_done", {31'd0, done}, 32'd0);
  endtask

  // Entered at the sample point of a SELECT cycle; leaves at the next SELECT.
  task automatic run_channel(input int ch, input int f, input int mx, input int dt, input int fl,
                             input int det_cycle, input logic [11:0] data, input int ready_delay);
    logic [5:0] oh;
    int n, last;
    oh = 6'd1 << ch;
    for (int i = 0; i < clamp1(f); i++) begin
      tick();
      chk("fill_sample", {26'd0, valve_sample}, {26'd0, oh});
      chk("fill_reagent", {26'd0, valve_reagent}, {26'd0, oh});
      chk("fill_mix", {26'd0, mix_en}, 32'd0);
    end
    for (int i = 0; i < clamp1(mx); i++) begin
      tick();
      chk("mix_en", {26'd0, mix_en}, {26'd0, oh});
      chk("mix_sample", {26'd0, valve_sample}, 32'd0);
    end
    n    = clamp1(dt);
    last = (det_cycle > 0) ? det_cycle : n;
    for (int i = 1; i <= last; i++) begin
      tick();
      chk("det_en", {26'd0, det_en}, {26'd0, oh});
      if (i == det_cycle) begin
        det_valid = 1'b1;
        det_data  = data;
      end
    end
    tick();
    det_valid = 1'b0;
    det_data  = 12'hABC;
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_ch", {29'd0, res_ch}, 32'(ch));
    chk("res_data", {20'd0, res_data}, (det_cycle > 0) ? {20'd0, data} : 32'd0);
    chk("res_timeout", {31'd0, res_timeout}, (det_cycle > 0) ? 32'd0 : 32'd1);
    chk("res_drives", {2'b0, drives()}, 32'd0);
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      chk("wait_valid", {31'd0, res_valid}, 32'd1);
      chk("wait_payload", {19'd0, res_timeout, res_data},
          (det_cycle > 0) ? {20'd0, data} : 32'h1000);
      chk("wait_ch", {29'd0, res_ch}, 32'(ch));
      chk("wait_drives", {2'b0, drives()}, 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("flush_en", {26'd0, flush_en}, {26'd0, oh});
    chk("flush_valid", {31'd0, res_valid}, 32'd0);
    for (int i = 1; i < clamp1(fl); i++) begin
      tick();
      chk("flush_en", {26'd0, flush_en}, {26'd0, oh});
    end
    tick();
    chk("sel_drives", {2'b0, drives()}, 32'd0);
    chk("sel_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_run();
    tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("finish_drives", {2'b0, drives()}, 32'd0);
    tick();
    chk("done_low", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ch_mask = '0;
    fill_cycles = '0; mix_cycles = '0; det_timeout = '0; flush_cycles = '0;
    det_valid = 1'b0; det_data = '0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_drives", {2'b0, drives()}, 32'd0);
    chk("rst_flags", {28'd0, res_valid, busy, done, res_timeout}, 32'd0);
    chk("rst_payload", {17'd0, res_ch, res_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Empty mask: done two cycles after start.
    start_run(6'b000000, 3, 3, 3, 3);
    finish_run();
    chk("empty_res_valid", {31'd0, res_valid}, 32'd0);

    // Channels 0 and 2, reading at DETECT cycle 2.
    start_run(6'b000101, 3, 4, 10, 2);
    run_channel(0, 3, 4, 10, 2, 2, 12'h3A5, 0);
    run_channel(2, 3, 4, 10, 2, 2, 12'h3A5, 0);
    finish_run();

    // Detector timeout after 5 cycles, consumer stalls 20 cycles.
    start_run(6'b000010, 1, 1, 5, 1);
    run_channel(1, 1, 1, 5, 1, 0, 12'h000, 20);
    finish_run();

    // Reading on the expiry cycle wins over timeout.
    start_run(6'b010000, 0, 0, 3, 0);
    run_channel(4, 0, 0, 3, 0, 3, 12'h7FF, 1);
    finish_run();

    // Reset during MIX on channel 3.
    start_run(6'b001000, 2, 5, 4, 2);
    tick(); tick();
    chk("pre_rst_fill", {26'd0, valve_sample}, 32'h08);
    tick(); tick();
    chk("pre_rst_mix", {26'd0, mix_en}, 32'h08);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_drives", {2'b0, drives()}, 32'd0);
    chk("midrst_flags", {29'd0, res_valid, busy, done}, 32'd0);
    tick();
    chk("midrst_idle", {30'd0, busy, done}, 32'd0);

    // All durations 0, lowest and highest channel.
    start_run(6'b100001, 0, 0, 0, 0);
    run_channel(0, 0, 0, 0, 0, 0, 12'h000, 0);
    run_channel(5, 0, 0, 0, 0, 1, 12'h123, 0);
    finish_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
